// File: rtl/regfile_multiport_pkg.sv
// Shared definitions for the register file: default sizes, clear-sequencer
// state type and the address-width helper.
package regfile_pkg;

  localparam int DEF_XLEN  = 32;
  localparam int DEF_NREGS = 32;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_RUN   = 1'b1
  } rf_state_e;

  // Address width for a power-of-two register count (at least one bit).
  function automatic int addrWidth(input int nregs);
    return (nregs <= 2) ? 1 : $clog2(nregs);
  endfunction

endpackage

// File: rtl/regfile_multiport_if.sv
// Bus between decode/writeback and the register file: one write port,
// NREAD flattened read ports and the status outputs.
interface regfile_multiport_if #(
  parameter int XLEN  = 32,
  parameter int AW    = 5,
  parameter int NREAD = 2
) ();

  logic                  write;
  logic [AW-1:0]         wr_addr;
  logic [XLEN-1:0]       wr_data;
  logic [NREAD*AW-1:0]   rd_addr;
  logic [NREAD*XLEN-1:0] rd_data;
  logic                  ready;
  logic                  wr_drop;

  modport master (
    output write, wr_addr, wr_data, rd_addr,
    input  rd_data, ready, wr_drop
  );

  modport slave (
    input  write, wr_addr, wr_data, rd_addr,
    output rd_data, ready, wr_drop
  );

endinterface

// File: rtl/regfile_multiport_clear_seq.sv
// Post-reset clear sequencer: walks every register index once, then
// reports ready and stays in RUN until the next reset.
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter  int NREGS = DEF_NREGS,
  localparam int AW    = addrWidth(NREGS)
) (
  input  logic          clk,
  input  logic          reset,
  output logic          clr_active,
  output logic [AW-1:0] clr_idx,
  output logic          ready
);

  rf_state_e state;

  assign clr_active = (state == RF_CLEAR);

  // State, clear index and ready flag; a reset at any point restarts at index 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RF_CLEAR;
      clr_idx <= '0;
      ready   <= 1'b0;
    end else if (state == RF_CLEAR) begin
      clr_idx <= clr_idx + 1'b1;
      if (clr_idx == AW'(NREGS - 1)) begin
        state <= RF_RUN;
        ready <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_multiport.sv
// Multi-read-port CPU register file with a single write port, registered
// reads, optional write-first forwarding, optional hard-wired zero register
// and a sequenced clear after reset.
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter  int XLEN     = DEF_XLEN,
  parameter  int NREGS    = DEF_NREGS,
  parameter  int NREAD    = 2,
  parameter  int BYPASS   = 1,
  parameter  int ZERO_REG = 1,
  localparam int AW       = addrWidth(NREGS)
) (
  input logic               clk,
  input logic               reset,
  regfile_multiport_if.slave bus
);

  logic [XLEN-1:0]       mem [NREGS];
  logic                  clrActive;
  logic [AW-1:0]         clrIdx;
  logic                  memWe;
  logic [AW-1:0]         memAddr;
  logic [XLEN-1:0]       memData;
  logic [AW-1:0]         ra;
  logic [NREAD*XLEN-1:0] rdNext;

  regfile_clear_seq #(.NREGS(NREGS)) u_clear (
    .clk       (clk),
    .reset     (reset),
    .clr_active(clrActive),
    .clr_idx   (clrIdx),
    .ready     (bus.ready)
  );

  // Write-port mux: the clear sequencer owns the port until RUN.
  always_comb begin
    memWe   = 1'b0;
    memAddr = bus.wr_addr;
    memData = bus.wr_data;
    if (!reset) begin
      if (clrActive) begin
        memWe   = 1'b1;
        memAddr = clrIdx;
        memData = '0;
      end else if (bus.write && !(ZERO_REG != 0 && bus.wr_addr == '0)) begin
        memWe = 1'b1;
      end
    end
  end

  // Single-write-port storage array.
  always_ff @(posedge clk) begin
    if (memWe) mem[memAddr] <= memData;
  end

  // Next read data per port; the zero-register test precedes forwarding so
  // a write to x0 can never leak onto a read of x0.
  always_comb begin
    rdNext = '0;
    ra     = '0;
    for (int unsigned k = 0; k < NREAD; k++) begin
      ra = bus.rd_addr[k*AW +: AW];
      if (ZERO_REG != 0 && ra == '0)
        rdNext[k*XLEN +: XLEN] = '0;
      else if (BYPASS != 0 && bus.write && bus.wr_addr == ra)
        rdNext[k*XLEN +: XLEN] = bus.wr_data;
      else
        rdNext[k*XLEN +: XLEN] = mem[ra];
    end
  end

  // Registered read data, forced to zero during reset and clear.
  always_ff @(posedge clk) begin
    if (reset || clrActive) bus.rd_data <= '0;
    else                    bus.rd_data <= rdNext;
  end

  // One-cycle flag for a write that arrived while the clear was running.
  always_ff @(posedge clk) begin
    if (reset) bus.wr_drop <= 1'b0;
    else       bus.wr_drop <= clrActive && bus.write;
  end

endmodule
